// File: rtl/vertex_scheduler_pkg.sv
// Shared types for the vertex scheduler: half-float vectors, raster points,
// FSM states and the f16 constants used as reset configuration.
package vertex_scheduler_pkg;

  typedef logic [15:0] f16;

  typedef struct packed {
    f16 x;
    f16 y;
  } vec2_f16;

  typedef struct packed {
    f16 x;
    f16 y;
    f16 z;
  } vec3_f16;

  typedef struct packed {
    logic signed [12:0] x;
    logic signed [12:0] y;
    logic signed [12:0] z;
  } vec3_i13;

  typedef enum logic [2:0] {
    IDLE,
    CONFIG,
    ISSUE,
    DRAIN,
    DONE
  } state_e;

  localparam f16 F16_ONE         = 16'h3C00;
  localparam f16 F16_TWO         = 16'h4000;
  localparam f16 F16_FIVE_TWELVE = 16'h6000;

endpackage

// File: rtl/vertex_scheduler_fetch_delay.sv
// Tracks outstanding vertex-memory reads: a valid shift register marks the
// cycle the memory data arrives, and the data is forwarded only in that cycle.
module vertex_fetch_delay #(
  parameter int RD_LATENCY = 2,
  parameter int W          = 48
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  output logic [W-1:0] out_data,
  output logic         pending
);

  logic [RD_LATENCY-1:0] vld_q, vld_d;

  always_comb begin
    vld_d = (vld_q << 1) | RD_LATENCY'(in_valid);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld_q <= '0;
    end else begin
      vld_q <= vld_d;
    end
  end

  // Memory data is only meaningful in the arrival cycle; zero it otherwise.
  assign out_valid = vld_q[RD_LATENCY-1];
  assign out_data  = out_valid ? in_data : '0;
  assign pending   = |vld_q;

endmodule

// File: rtl/vertex_scheduler.sv
// Batch vertex scheduler: fetches N vertices under an in-flight credit limit,
// feeds them to the projection pipeline and writes returned raster points in order.
module vertex_scheduler
  import vertex_scheduler_pkg::*;
#(
  parameter int MAX_INFLIGHT = 8,
  parameter int RD_LATENCY   = 2,
  parameter int ADDR_W       = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] vertex_count,
  input  logic              stall,
  input  f16                cfg_near_clip,
  input  vec2_f16           cfg_canvas,
  input  vec2_f16           cfg_image,
  output f16                cam_near_clip,
  output vec2_f16           canvas_dimensions,
  output vec2_f16           image_dimensions,
  output logic              vtx_rd_en,
  output logic [ADDR_W-1:0] vtx_rd_addr,
  input  vec3_f16           vtx_rd_data,
  output vec3_f16           vertex_3d,
  output logic              vertex_3d_valid,
  input  vec3_i13           rast_pt,
  input  logic              rast_pt_valid,
  output logic              out_wr_en,
  output logic [ADDR_W-1:0] out_wr_addr,
  output vec3_i13           out_wr_data,
  output logic              busy,
  output logic              done,
  output logic              error,
  output state_e            dbg_state
);

  localparam logic [ADDR_W-1:0] MAX_INF = ADDR_W'(MAX_INFLIGHT);
  localparam logic [ADDR_W-1:0] ONE_A   = ADDR_W'(1);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] n_q, n_d;
  logic [ADDR_W-1:0] issued_q, issued_d;
  logic [ADDR_W-1:0] returned_q, returned_d;
  logic [ADDR_W-1:0] inflight_q, inflight_d;
  logic              error_q, error_d;
  f16                near_q, near_d;
  vec2_f16           canvas_q, canvas_d;
  vec2_f16           image_q, image_d;

  logic issue, ret_ok, stray, fetch_pending;

  // Valid/ready contract: a read issues only with a free credit and no stall;
  // a return is always accepted, and one arriving with no credit out is a protocol error.
  always_comb begin
    issue  = (state_q == ISSUE) && (issued_q < n_q) && (inflight_q < MAX_INF) && !stall;
    ret_ok = rast_pt_valid && (inflight_q != '0);
    stray  = rast_pt_valid && (inflight_q == '0);
  end

  always_comb begin
    state_d    = state_q;
    n_d        = n_q;
    issued_d   = issued_q;
    returned_d = returned_q;
    inflight_d = inflight_q;
    error_d    = error_q;
    near_d     = near_q;
    canvas_d   = canvas_q;
    image_d    = image_q;

    case (state_q)
      IDLE: begin
        // Captured on the start edge so they are already stable during CONFIG.
        if (start) begin
          state_d  = CONFIG;
          n_d      = vertex_count;
          near_d   = cfg_near_clip;
          canvas_d = cfg_canvas;
          image_d  = cfg_image;
        end
      end
      CONFIG: begin
        state_d = (n_q == '0) ? DONE : ISSUE;
      end
      ISSUE: begin
        if (issue && (issued_q + ONE_A == n_q)) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if ((inflight_q == '0) && !fetch_pending) begin
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (state_q == CONFIG) begin
      issued_d   = '0;
      returned_d = '0;
      inflight_d = '0;
      error_d    = 1'b0;
    end else begin
      issued_d   = issued_q + ADDR_W'(issue);
      returned_d = returned_q + ADDR_W'(ret_ok);
      inflight_d = inflight_q + ADDR_W'(issue) - ADDR_W'(ret_ok);
    end

    if (stray) begin
      error_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      n_q        <= '0;
      issued_q   <= '0;
      returned_q <= '0;
      inflight_q <= '0;
      error_q    <= 1'b0;
      near_q     <= F16_ONE;
      canvas_q   <= '{x: F16_TWO, y: F16_TWO};
      image_q    <= '{x: F16_FIVE_TWELVE, y: F16_FIVE_TWELVE};
    end else begin
      state_q    <= state_d;
      n_q        <= n_d;
      issued_q   <= issued_d;
      returned_q <= returned_d;
      inflight_q <= inflight_d;
      error_q    <= error_d;
      near_q     <= near_d;
      canvas_q   <= canvas_d;
      image_q    <= image_d;
    end
  end

  vertex_fetch_delay #(
    .RD_LATENCY(RD_LATENCY),
    .W         ($bits(vec3_f16))
  ) u_fetch_delay (
    .clk      (clk),
    .rst      (rst),
    .in_valid (issue),
    .in_data  (vtx_rd_data),
    .out_valid(vertex_3d_valid),
    .out_data (vertex_3d),
    .pending  (fetch_pending)
  );

  assign vtx_rd_en         = issue;
  assign vtx_rd_addr       = issued_q;
  assign out_wr_en         = ret_ok;
  assign out_wr_addr       = returned_q;
  assign out_wr_data       = ret_ok ? rast_pt : '0;
  assign cam_near_clip     = near_q;
  assign canvas_dimensions = canvas_q;
  assign image_dimensions  = image_q;
  assign busy              = (state_q == CONFIG) || (state_q == ISSUE) || (state_q == DRAIN);
  assign done              = (state_q == DONE);
  assign error             = error_q;
  assign dbg_state         = state_q;

endmodule

// File: doc/vertex_scheduler.md
VERTEX_SCHEDULER -- requirements
Module: vertex_scheduler

Interface
REQ-001 Parameter MAX_INFLIGHT, default 8: maximum vertices issued but not yet returned as raster points.
REQ-002 Parameter RD_LATENCY, default 2: cycles from vtx_rd_en to valid vtx_rd_data.
REQ-003 Parameter ADDR_W, default 16: width of vertex_count and of all memory addresses.
REQ-004 clk  in  1  sole clock, rising edge.
REQ-005 rst  in  1  reset, asynchronous, active-low (asserted at 0).
REQ-006 start  in  1  one-cycle request to begin a batch.
REQ-007 vertex_count  in  ADDR_W  number of vertices N in the batch.
REQ-008 stall  in  1  when high, no new vertex reads are issued.
REQ-009 cfg_near_clip  in  f16  near-clip value, sampled at start.
REQ-010 cfg_canvas  in  vec2_f16  canvas dimensions, sampled at start.
REQ-011 cfg_image  in  vec2_f16  image dimensions, sampled at start.
REQ-012 cam_near_clip / canvas_dimensions / image_dimensions  out  f16 / vec2_f16 / vec2_f16  registered configuration driven to the projection pipeline.
REQ-013 vtx_rd_en / vtx_rd_addr  out  1 / ADDR_W  vertex-memory read strobe and address.
REQ-014 vtx_rd_data  in  vec3_f16  vertex-memory read data.
REQ-015 vertex_3d / vertex_3d_valid  out  vec3_f16 / 1  vertex fed to the projection pipeline.
REQ-016 rast_pt / rast_pt_valid  in  vec3_i13 / 1  in-order result from the rasterize stage.
REQ-017 out_wr_en / out_wr_addr / out_wr_data  out  1 / ADDR_W / vec3_i13  result-memory write port.
REQ-018 busy / done / error  out  1 / 1 / 1  batch active; one-cycle completion pulse; sticky protocol error.

Function
REQ-019 FSM states SHALL be IDLE, CONFIG, ISSUE, DRAIN, DONE.
REQ-020 IDLE->CONFIG on start; start in any other state SHALL be ignored.
REQ-021 CONFIG (one cycle): latch N and the cfg_* inputs into the configuration outputs, clear the counters and error; go to DONE if N==0, else ISSUE.
REQ-022 ISSUE: assert vtx_rd_en with vtx_rd_addr=issued when issued<N, inflight<MAX_INFLIGHT and !stall, then increment issued and inflight.
REQ-023 ISSUE->DRAIN in the cycle issued reaches N; DRAIN->DONE when inflight==0 and no reads are pending.
REQ-024 DONE: assert done for exactly one cycle, then go to IDLE.
REQ-025 vertex_3d_valid SHALL assert exactly RD_LATENCY cycles after each vtx_rd_en, with vertex_3d=vtx_rd_data, via a valid shift register.
REQ-026 Each rast_pt_valid SHALL produce out_wr_en in the same cycle, with out_wr_addr=returned, out_wr_data=rast_pt, then returned++ and inflight--.
REQ-027 An issue and a return in the same cycle SHALL leave inflight unchanged.
REQ-028 If rast_pt_valid arrives while inflight==0: set error, suppress out_wr_en, leave counters unchanged.
REQ-029 Configuration outputs SHALL stay constant from CONFIG until the next CONFIG.
REQ-030 busy SHALL be high in CONFIG, ISSUE and DRAIN, and low in IDLE and DONE.
REQ-031 Counters SHALL be ADDR_W bits and SHALL NOT wrap; the maximum N is 2^ADDR_W-1.

Reset
REQ-032 While rst==0: state=IDLE and all counters, strobes, busy, done, error, out_wr_*, vtx_rd_* and vertex_3d* = 0.
REQ-033 While rst==0: cam_near_clip=16'h3C00, canvas_dimensions={16'h4000,16'h4000}, image_dimensions={16'h6000,16'h6000}.
REQ-034 Reset asserted mid-batch SHALL abandon the batch; results returned after reset release SHALL set error.

Structure
REQ-035 The state enum, the f16 constants ONE, TWO and FIVE_TWELVE, and the vec* typedefs SHALL live in the shared types package.
REQ-036 The read-latency valid/data delay line SHALL be one sub-module, vertex_fetch_delay, parameterised by RD_LATENCY.

Verification
REQ-037 N=5, no stall, pipeline latency 10: reads at addresses 0..4 on consecutive cycles; five writes to addresses 0..4 in order; done pulses once; busy then falls.
REQ-038 N=20, MAX_INFLIGHT=8, pipeline latency 30: inflight never exceeds 8; issue resumes on the cycle after the first return; 20 writes in total.
REQ-039 N=4 with stall high for cycles 2-6: vtx_rd_en is low throughout the stall; all 4 results are still written; done pulses once.
REQ-040 N=0: start -> CONFIG -> DONE; done pulses 2 cycles after start; no reads and no writes.
REQ-041 rast_pt_valid injected in IDLE: error=1 and no write; error clears at the next CONFIG.
REQ-042 rst driven low in the middle of an N=10 batch: all outputs take their reset values asynchronously; the configuration outputs return to 1.0, 2.0 and 512.0.
